irq_pending_ctrl: RTL and testbench
===================================

# irq_pending_ctrl

Edge-triggered interrupt front end: captures rising edges on N request lines into a pending register and applies a software mask. It drives the enabled-pending vector into an internal `Encoder` instance (highest index wins) and presents the winning ID to the CPU over a valid/ready handshake. It then holds off further offers until end-of-interrupt. It sits between raw peripheral IRQ lines and the core's trap logic.

## Interface
- `ID_WIDTH`, default 3: width of the interrupt ID; passed to `Encoder` as `OUT_WIDTH`.
- `N` (localparam) = `1 << ID_WIDTH`: number of request lines.
- `clk`  in  1  sole clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `irq_in`  in  N  raw request lines, synchronous to `clk`.
- `mask_we`  in  1  mask write strobe.
- `mask_wdata`  in  N  new mask value; bit set = line masked.
- `irq_valid`  out  1  an interrupt ID is offered.
- `irq_id`  out  ID_WIDTH  offered ID; stable while `irq_valid`.
- `irq_ready`  in  1  CPU accepts the offered ID.
- `eoi`  in  1  end-of-interrupt pulse from CPU.
- `busy`  out  1  an accepted interrupt is in service.
- `pending`  out  N  current pending register.
- `mask`  out  N  current mask register.

## Operation
- Edge detect: `irq_prev` register. Edge vector = `irq_in & ~irq_prev`. `irq_prev` resets to 0, so a line already high at reset release counts as an edge on the first sampled cycle.
- Pending update each edge: `pending_next = (pending & ~clr) | edge`. `clr` is one-hot at `irq_id` on a transfer (`irq_valid & irq_ready`), else 0. Set wins over clear on the same bit.
- Mask: `mask_we` loads `mask_wdata` at the next edge. A masked line still latches into pending; it is only excluded from selection.
- `Encoder.in = pending & ~mask`. `any = |(pending & ~mask)`. `Encoder.out` is meaningful only when `any`.
- FSM, 3 states:
  - IDLE: if `any`, load `irq_id <= Encoder.out` and go to OFFER; else stay.
  - OFFER: `irq_valid = 1`. `irq_id` and `irq_valid` must not change until transfer, even if that line is masked or a higher ID becomes pending. On transfer, clear the pending bit and go to BUSY.
  - BUSY: `busy = 1`. Edges keep latching. `eoi` returns to IDLE.
- `eoi` is ignored in IDLE and OFFER. `irq_ready` is ignored outside OFFER.
- No nesting and no preemption.
- Reset values: `irq_valid`=0, `irq_id`=0, `busy`=0, `pending`=0, `mask`=all ones, `irq_prev`=0, state=IDLE.
- Reset is asynchronous and may occur mid-offer or mid-service: all state clears immediately, and any in-flight offer is dropped.

## Timing
- `irq_in` rising, sampled at edge k: `pending` bit visible after k. State goes to OFFER at edge k+1, so `irq_valid` is high in cycle k+1..k+2.
- Edge-to-`irq_valid` latency: 2 cycles. With `irq_ready` high on first offer, the transfer happens at edge k+2 and `busy` is high after k+2.
- `eoi` at edge m: IDLE after m. If `any`, OFFER after m+1.
- Minimum spacing between successive offers: 1 cycle of IDLE.
- Mask write at edge j affects selection from cycle j+1.
- `irq_valid`, `irq_id`, `busy` are registered. `pending` and `mask` are register outputs.
- There is no combinational path from inputs to outputs.

## Test plan
- Reset release with `irq_in`=0x04 and mask written to 0x00 on the first cycle: `pending`=0x04. `irq_valid` rises with `irq_id`=2. `irq_ready`=1 clears pending to 0x00 and `busy`=1.
- Simultaneous edges 0x81, mask 0x00: offer ID 7. After transfer and `eoi`, the next offer is ID 0 exactly 2 cycles after the `eoi` edge.
- During OFFER of ID 3 with `irq_ready`=0, raise line 6 and mask line 3: `irq_id` stays 3 and `irq_valid` stays 1 until ready. Next offer after `eoi` is 6.
- Mask 0xFF with pulse on line 5: `pending`=0x20 and no `irq_valid`. Writing mask 0x00 gives `irq_valid`, `irq_id`=5 two cycles later.
- New edge on line 4 in the same cycle line 4 is accepted: `pending` bit 4 remains 1 after transfer. A second offer of ID 4 follows `eoi`.
- Assert `rst_n`=0 mid-BUSY and mid-OFFER: all outputs go to their reset values without a clock edge. `mask` = 0xFF.

Source files
------------

// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - edge-capturing interrupt pending/mask front end with priority offer FSM
// Highest enabled pending index is offered over valid/ready; no further offer until eoi.

module encoder #(
  parameter int OUT_WIDTH = 3
) (
  input  logic [(1<<OUT_WIDTH)-1:0] i_in,
  output logic [OUT_WIDTH-1:0]      o_out
);
  localparam int IN_WIDTH = 1 << OUT_WIDTH;

  // Ascending scan so the last set bit, i.e. the highest index, wins.
  always_comb begin
    o_out = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (i_in[i]) o_out = OUT_WIDTH'(i);
    end
  end
endmodule

module irq_pending_ctrl #(
  parameter int ID_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [(1<<ID_WIDTH)-1:0]     irq_in,
  input  logic                         mask_we,
  input  logic [(1<<ID_WIDTH)-1:0]     mask_wdata,
  output logic                         irq_valid,
  output logic [ID_WIDTH-1:0]          irq_id,
  input  logic                         irq_ready,
  input  logic                         eoi,
  output logic                         busy,
  output logic [(1<<ID_WIDTH)-1:0]     pending,
  output logic [(1<<ID_WIDTH)-1:0]     mask
);
  localparam int N = 1 << ID_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [N-1:0]        r_irq_prev;
  logic [N-1:0]        r_pending;
  logic [N-1:0]        r_mask;
  logic [ID_WIDTH-1:0] r_irq_id;
  logic                r_irq_valid;
  logic                r_busy;

  logic [N-1:0]        w_edge;
  logic [N-1:0]        w_clr;
  logic [N-1:0]        w_enabled;
  logic                w_any;
  logic                w_transfer;
  logic [ID_WIDTH-1:0] w_enc_out;

  assign w_edge     = irq_in & ~r_irq_prev;
  assign w_enabled  = r_pending & ~r_mask;
  assign w_any      = |w_enabled;
  assign w_transfer = r_irq_valid & irq_ready;

  always_comb begin
    w_clr = '0;
    if (w_transfer) w_clr[r_irq_id] = 1'b1;
  end

  encoder #(
    .OUT_WIDTH(ID_WIDTH)
  ) u_encoder (
    .i_in (w_enabled),
    .o_out(w_enc_out)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any)      w_state_next = S_OFFER;
      S_OFFER: if (w_transfer) w_state_next = S_BUSY;
      S_BUSY:  if (eoi)        w_state_next = S_IDLE;
      default:                 w_state_next = S_IDLE;
    endcase
  end

  // valid/busy are flopped from the next state so the outputs carry no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_irq_prev  <= '0;
      r_pending   <= '0;
      r_mask      <= '1;
      r_irq_id    <= '0;
      r_irq_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_irq_prev  <= irq_in;
      r_pending   <= (r_pending & ~w_clr) | w_edge;
      if (mask_we) r_mask <= mask_wdata;
      if (r_state == S_IDLE && w_any) r_irq_id <= w_enc_out;
      r_irq_valid <= (w_state_next == S_OFFER);
      r_busy      <= (w_state_next == S_BUSY);
    end
  end

  assign irq_valid = r_irq_valid;
  assign irq_id    = r_irq_id;
  assign busy      = r_busy;
  assign pending   = r_pending;
  assign mask      = r_mask;
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb/tb_irq_pending_ctrl.sv - table-driven scoreboard bench for irq_pending_ctrl
module tb_irq_pending_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq_in = '0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = '0;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic       irq_ready = 1'b0;
  logic       eoi = 1'b0;
  logic       busy;
  logic [7:0] pending;
  logic [7:0] mask;

  int checks = 0;
  int failures = 0;

  irq_pending_ctrl #(.ID_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .irq_valid(irq_valid), .irq_id(irq_id),
    .irq_ready(irq_ready), .eoi(eoi), .busy(busy), .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
    logic       busy;
    logic [7:0] pending;
    logic [7:0] mask;
  } out_t;

  typedef struct packed {
    logic [7:0] irq_in;
    logic       we;
    logic [7:0] wdata;
    logic       ready;
    logic       eoi;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];

  function automatic void add(input logic [7:0] i, input logic we, input logic [7:0] wd,
                              input logic rdy, input logic e, input logic v,
                              input logic [2:0] id, input logic b,
                              input logic [7:0] p, input logic [7:0] m);
    vec_t t;
    t.irq_in = i; t.we = we; t.wdata = wd; t.ready = rdy; t.eoi = e;
    t.exp.valid = v; t.exp.id = id; t.exp.busy = b; t.exp.pending = p; t.exp.mask = m;
    vecs.push_back(t);
  endfunction

  task automatic compare(input string name, input out_t want);
    out_t got;
    got.valid = irq_valid; got.id = irq_id; got.busy = busy;
    got.pending = pending; got.mask = mask;
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got valid=%0d id=%0d busy=%0d pending=%02h mask=%02h, want valid=%0d id=%0d busy=%0d pending=%02h mask=%02h",
               name, got.valid, got.id, got.busy, got.pending, got.mask,
               want.valid, want.id, want.busy, want.pending, want.mask);
    end
  endtask

  // Called at posedge+1: drive, push expectation, clock once, pop and compare.
  task automatic step(input vec_t v, input string name);
    out_t want;
    irq_in = v.irq_in; mask_we = v.we; mask_wdata = v.wdata;
    irq_ready = v.ready; eoi = v.eoi;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      want = sb.pop_front();
      compare(name, want);
    end
  endtask

  task automatic async_reset_check(input string name);
    out_t rst_exp;
    rst_exp = '{valid: 1'b0, id: 3'd0, busy: 1'b0, pending: 8'h00, mask: 8'hFF};
    #2;
    rst_n = 1'b0;
    #1;
    compare(name, rst_exp);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //  irq  we wdata rdy eoi | vld id busy pend mask
    // reset release with line 2 high, mask opened on first cycle
    add(8'h04,1,8'h00,1,0, 0,3'd0,0,8'h04,8'h00);
    add(8'h04,0,8'h00,1,0, 1,3'd2,0,8'h04,8'h00);
    add(8'h04,0,8'h00,1,0, 0,3'd2,1,8'h00,8'h00);
    add(8'h00,0,8'h00,0,0, 0,3'd2,1,8'h00,8'h00);
    add(8'h00,0,8'h00,0,1, 0,3'd2,0,8'h00,8'h00);
    add(8'h00,0,8'h00,0,0, 0,3'd2,0,8'h00,8'h00);
    // simultaneous edges 0x81: ID 7 then ID 0 after eoi
    add(8'h81,0,8'h00,0,0, 0,3'd2,0,8'h81,8'h00);
    add(8'h81,0,8'h00,0,0, 1,3'd7,0,8'h81,8'h00);
    add(8'h81,0,8'h00,1,0, 0,3'd7,1,8'h01,8'h00);
    add(8'h81,0,8'h00,0,1, 0,3'd7,0,8'h01,8'h00);
    add(8'h81,0,8'h00,0,0, 1,3'd0,0,8'h01,8'h00);
    add(8'h81,0,8'h00,1,0, 0,3'd0,1,8'h00,8'h00);
    add(8'h00,0,8'h00,0,1, 0,3'd0,0,8'h00,8'h00);
    // offer of 3 held while line 6 rises and line 3 is masked
    add(8'h08,0,8'h00,0,0, 0,3'd0,0,8'h08,8'h00);
    add(8'h08,0,8'h00,0,0, 1,3'd3,0,8'h08,8'h00);
    add(8'h48,1,8'h08,0,0, 1,3'd3,0,8'h48,8'h08);
    add(8'h48,0,8'h00,0,0, 1,3'd3,0,8'h48,8'h08);
    add(8'h48,0,8'h00,1,0, 0,3'd3,1,8'h40,8'h08);
    add(8'h48,0,8'h00,0,1, 0,3'd3,0,8'h40,8'h08);
    add(8'h48,0,8'h00,0,0, 1,3'd6,0,8'h40,8'h08);
    add(8'h48,0,8'h00,1,0, 0,3'd6,1,8'h00,8'h08);
    add(8'h00,1,8'hFF,0,1, 0,3'd6,0,8'h00,8'hFF);
    // masked pulse on line 5 stays pending until unmasked
    add(8'h20,0,8'h00,0,0, 0,3'd6,0,8'h20,8'hFF);
    add(8'h00,0,8'h00,0,0, 0,3'd6,0,8'h20,8'hFF);
    add(8'h00,0,8'h00,0,0, 0,3'd6,0,8'h20,8'hFF);
    add(8'h00,1,8'h00,0,0, 0,3'd6,0,8'h20,8'h00);
    add(8'h00,0,8'h00,0,0, 1,3'd5,0,8'h20,8'h00);
    add(8'h00,0,8'h00,1,0, 0,3'd5,1,8'h00,8'h00);
    add(8'h00,0,8'h00,0,1, 0,3'd5,0,8'h00,8'h00);
    // re-edge on line 4 in the accept cycle survives the clear
    add(8'h10,0,8'h00,0,0, 0,3'd5,0,8'h10,8'h00);
    add(8'h00,0,8'h00,0,0, 1,3'd4,0,8'h10,8'h00);
    add(8'h10,0,8'h00,1,0, 0,3'd4,1,8'h10,8'h00);
    add(8'h00,0,8'h00,0,1, 0,3'd4,0,8'h10,8'h00);
    add(8'h00,0,8'h00,0,0, 1,3'd4,0,8'h10,8'h00);
    add(8'h00,0,8'h00,1,0, 0,3'd4,1,8'h00,8'h00);
    add(8'h00,0,8'h00,0,1, 0,3'd4,0,8'h00,8'h00);
    // set up an offer of ID 1 for the reset sequence
    add(8'h02,0,8'h00,0,0, 0,3'd4,0,8'h02,8'h00);
    add(8'h02,0,8'h00,0,0, 1,3'd1,0,8'h02,8'h00);

    irq_in = 8'h04;
    repeat (3) @(posedge clk);
    #1;
    compare("reset_state", '{valid: 1'b0, id: 3'd0, busy: 1'b0, pending: 8'h00, mask: 8'hFF});
    rst_n = 1'b1;
    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    async_reset_check("reset_mid_offer");
    step('{irq_in: 8'h02, we: 1'b1, wdata: 8'h00, ready: 1'b0, eoi: 1'b0,
           exp: '{valid: 1'b0, id: 3'd0, busy: 1'b0, pending: 8'h02, mask: 8'h00}}, "post_rst_edge");
    step('{irq_in: 8'h02, we: 1'b0, wdata: 8'h00, ready: 1'b0, eoi: 1'b0,
           exp: '{valid: 1'b1, id: 3'd1, busy: 1'b0, pending: 8'h02, mask: 8'h00}}, "post_rst_offer");
    step('{irq_in: 8'h02, we: 1'b0, wdata: 8'h00, ready: 1'b1, eoi: 1'b0,
           exp: '{valid: 1'b0, id: 3'd1, busy: 1'b1, pending: 8'h00, mask: 8'h00}}, "post_rst_busy");
    async_reset_check("reset_mid_busy");
    step('{irq_in: 8'h02, we: 1'b0, wdata: 8'h00, ready: 1'b1, eoi: 1'b1,
           exp: '{valid: 1'b0, id: 3'd0, busy: 1'b0, pending: 8'h02, mask: 8'hFF}}, "post_rst_masked");

    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
